// File: rtl/timer_ctrl_if.sv
// Handshake bundle between the kitchen-timer control block and its keypad/counter neighbours.
// door_closed exists only when TIMER_CTRL_DOOR_EN is defined.
interface timer_ctrl_if;
    logic       clear;
    logic       start;
    logic       stop;
    logic       key_valid;
    logic [3:0] key_digit;
`ifdef TIMER_CTRL_DOOR_EN
    logic       door_closed;
`endif
    logic       zero;
    logic [3:0] min_in;
    logic [3:0] sec_tens_in;
    logic [3:0] sec_ones_in;
    logic       load;
    logic       en;
    logic       clearn;
    logic       running;
    logic       done;
    logic [2:0] state;

    modport master (
        output clear, start, stop, key_valid, key_digit,
`ifdef TIMER_CTRL_DOOR_EN
        output door_closed,
`endif
        output zero,
        input  min_in, sec_tens_in, sec_ones_in, load, en, clearn, running, done, state
    );

    modport slave (
        input  clear, start, stop, key_valid, key_digit,
`ifdef TIMER_CTRL_DOOR_EN
        input  door_closed,
`endif
        input  zero,
        output min_in, sec_tens_in, sec_ones_in, load, en, clearn, running, done, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// Kitchen-timer control: keypad entry buffer, load/tick/clear drive for the digit counters.
// Optional door interlock enabled by defining TIMER_CTRL_DOOR_EN.
module timer_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    timer_ctrl_if.slave io_bus
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSet   = 3'd1,
        StLoad  = 3'd2,
        StRun   = 3'd3,
        StPause = 3'd4,
        StDone  = 3'd5
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [3:0]    r_min, r_tens, r_ones;
    logic [3:0]    w_min_next, w_tens_next, w_ones_next;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          w_digit_ok;
    logic          w_door;
    logic          w_buf_zero;

`ifdef TIMER_CTRL_DOOR_EN
    assign w_door = io_bus.door_closed;
`else
    assign w_door = 1'b1;
`endif

    assign w_digit_ok = io_bus.key_valid && (io_bus.key_digit <= 4'd9);
    assign w_buf_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_min   <= 4'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_next;
            r_min   <= w_min_next;
            r_tens  <= w_tens_next;
            r_ones  <= w_ones_next;
            r_presc <= w_presc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_min_next   = r_min;
        w_tens_next  = r_tens;
        w_ones_next  = r_ones;
        w_presc_next = r_presc;
        if (io_bus.clear) begin
            w_state_next = StIdle;
            w_min_next   = 4'd0;
            w_tens_next  = 4'd0;
            w_ones_next  = 4'd0;
            w_presc_next = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_digit_ok) begin
                        w_min_next   = r_tens;
                        w_tens_next  = r_ones;
                        w_ones_next  = io_bus.key_digit;
                        w_state_next = StSet;
                    end
                end
                StSet: begin
                    // A valid start swallows a coincident digit; an ignored start does not.
                    if (io_bus.start && w_door && !w_buf_zero) begin
                        if (r_tens > 4'd5) begin
                            w_tens_next = 4'd5;
                        end
                        w_state_next = StLoad;
                    end else if (w_digit_ok) begin
                        w_min_next  = r_tens;
                        w_tens_next = r_ones;
                        w_ones_next = io_bus.key_digit;
                    end
                end
                StLoad: begin
                    w_presc_next = '0;
                    w_state_next = StRun;
                end
                StRun: begin
                    w_presc_next = (r_presc == TERM) ? '0 : r_presc + PW'(1);
                    if (io_bus.zero) begin
                        w_state_next = StDone;
                    end else if (io_bus.stop || !w_door) begin
                        w_state_next = StPause;
                    end
                end
                StPause: begin
                    if (io_bus.start && w_door) begin
                        w_state_next = StRun;
                    end
                end
                StDone: begin
                    if (w_digit_ok) begin
                        w_min_next   = 4'd0;
                        w_tens_next  = 4'd0;
                        w_ones_next  = io_bus.key_digit;
                        w_state_next = StSet;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // en is combinational on zero so the counters never wrap past 0:00.
    assign io_bus.en          = (r_state == StRun) && (r_presc == TERM) && !io_bus.zero;
    assign io_bus.load        = (r_state == StLoad);
    assign io_bus.clearn      = (r_state != StIdle);
    assign io_bus.running     = (r_state == StRun);
    assign io_bus.done        = (r_state == StDone);
    assign io_bus.state       = r_state;
    assign io_bus.min_in      = r_min;
    assign io_bus.sec_tens_in = r_tens;
    assign io_bus.sec_ones_in = r_ones;
endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed test-plan steps, then random stimulus against a
// decimal-arithmetic reference model of the timer.
module tb_timer_ctrl;
    localparam int TICK = 4;
    localparam int S_IDLE = 0, S_SET = 1, S_LOAD = 2, S_RUN = 3, S_PAUSE = 4, S_DONE = 5;
`ifdef TIMER_CTRL_DOOR_EN
    localparam bit DOOR_EN = 1'b1;
`else
    localparam bit DOOR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   en_seen = 0;

    // Model: buffer held as a decimal number 0..999, prescaler as elapsed ticks.
    int   m_state;
    int   m_buf;
    int   m_ticks;
    bit   m_zr;

    timer_ctrl_if bus ();

    timer_ctrl #(.TICK_DIV(TICK)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_buf   = 0;
        m_ticks = 0;
    endtask

    task automatic model_step(input bit clr, input bit st, input bit sp, input bit kv,
                              input int kd, input bit dr, input bit zr);
        bit acc;
        bit door;
        int tens;
        acc  = kv && (kd <= 9);
        door = dr || !DOOR_EN;
        if (clr) begin
            m_state = S_IDLE;
            m_buf   = 0;
            m_ticks = 0;
        end else if (m_state == S_IDLE) begin
            if (acc) begin
                m_buf   = (m_buf * 10 + kd) % 1000;
                m_state = S_SET;
            end
        end else if (m_state == S_SET) begin
            if (st && door && m_buf != 0) begin
                tens = (m_buf / 10) % 10;
                if (tens > 5) m_buf = m_buf - (tens - 5) * 10;
                m_state = S_LOAD;
            end else if (acc) begin
                m_buf = (m_buf * 10 + kd) % 1000;
            end
        end else if (m_state == S_LOAD) begin
            m_ticks = 0;
            m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            m_ticks = (m_ticks + 1) % TICK;
            if (zr) m_state = S_DONE;
            else if (sp || !door) m_state = S_PAUSE;
        end else if (m_state == S_PAUSE) begin
            if (st && door) m_state = S_RUN;
        end else if (m_state == S_DONE) begin
            if (acc) begin
                m_buf   = kd;
                m_state = S_SET;
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_en;
        exp_en = (m_state == S_RUN) && (m_ticks == TICK - 1) && !m_zr;
        if (bus.en === 1'b1) en_seen++;
        chk("state", 32'(bus.state), m_state);
        chk("load", 32'(bus.load), (m_state == S_LOAD) ? 1 : 0);
        chk("en", 32'(bus.en), exp_en ? 1 : 0);
        chk("clearn", 32'(bus.clearn), (m_state != S_IDLE) ? 1 : 0);
        chk("running", 32'(bus.running), (m_state == S_RUN) ? 1 : 0);
        chk("done", 32'(bus.done), (m_state == S_DONE) ? 1 : 0);
        chk("min_in", 32'(bus.min_in), m_buf / 100);
        chk("sec_tens_in", 32'(bus.sec_tens_in), (m_buf / 10) % 10);
        chk("sec_ones_in", 32'(bus.sec_ones_in), m_buf % 10);
    endtask

    task automatic cycle(input bit clr, input bit st, input bit sp, input bit kv,
                         input int kd, input bit dr, input bit zr);
        @(negedge clk);
        bus.clear     = clr;
        bus.start     = st;
        bus.stop      = sp;
        bus.key_valid = kv;
        bus.key_digit = 4'(kd);
`ifdef TIMER_CTRL_DOOR_EN
        bus.door_closed = dr;
`endif
        bus.zero      = zr;
        m_zr          = zr;
        #1 check_outputs();
        @(posedge clk);
        model_step(clr, st, sp, kv, kd, dr, zr);
    endtask

    task automatic idle_cyc();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic key(input int d);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 0);
        chk({tag, "_load"}, 32'(bus.load), 0);
        chk({tag, "_en"}, 32'(bus.en), 0);
        chk({tag, "_clearn"}, 32'(bus.clearn), 0);
        chk({tag, "_running"}, 32'(bus.running), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_buf"}, 32'({bus.min_in, bus.sec_tens_in, bus.sec_ones_in}), 0);
    endtask

    initial begin
        bit found;
        rst           = 1'b0;
        bus.clear     = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
`ifdef TIMER_CTRL_DOOR_EN
        bus.door_closed = 1'b1;
`endif
        bus.zero      = 1'b0;
        m_zr          = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        idle_cyc();

        // Entry: keys 1,3,0
        key(1);
        #2 chk("first_key_state", 32'(bus.state), S_SET);
        chk("first_key_clearn", 32'(bus.clearn), 1);
        key(3);
        key(0);
        #2 chk("buf_130", 32'({bus.min_in, bus.sec_tens_in, bus.sec_ones_in}), 32'h130);

        // Oldest digit discarded, invalid digit ignored
        key(2); key(7); key(5); key(9);
        key(12);
        #2 chk("buf_759", 32'({bus.min_in, bus.sec_tens_in, bus.sec_ones_in}), 32'h759);
        chk("key12_state", 32'(bus.state), S_SET);

        // start -> LOAD with tens clamped
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        #2 chk("load_strobe", 32'(bus.load), 1);
        chk("tens_clamped", 32'(bus.sec_tens_in), 5);
        idle_cyc();
        en_seen = 0;
        repeat (12) idle_cyc();
        chk("en_count_12cyc", en_seen, 3);

        // Pause and resume
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        #2 chk("paused", 32'(bus.state), S_PAUSE);
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        repeat (3) idle_cyc();

        // zero coincident with terminal prescaler value
        found = 1'b0;
        for (int i = 0; i < 2 * TICK && !found; i++) begin
            if (m_state == S_RUN && m_ticks == TICK - 1) found = 1'b1;
            else idle_cyc();
        end
        chk("reach_terminal", 32'(found), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        #2 chk("done_state", 32'(bus.done), 1);
        key(4);
        #2 chk("buf_004", 32'({bus.min_in, bus.sec_tens_in, bus.sec_ones_in}), 32'h004);
        chk("done_key_state", 32'(bus.state), S_SET);

        // clear beats start
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        #2 chk("clear_state", 32'(bus.state), S_IDLE);
        chk("clear_load", 32'(bus.load), 0);
        chk("clear_clearn", 32'(bus.clearn), 0);
        chk("clear_buf", 32'({bus.min_in, bus.sec_tens_in, bus.sec_ones_in}), 0);

        if (DOOR_EN) begin
            key(5);
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            #2 chk("door_open_start", 32'(bus.state), S_SET);
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
            idle_cyc();
            idle_cyc();
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            #2 chk("door_open_pause", 32'(bus.state), S_PAUSE);
            en_seen = 0;
            repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            chk("door_open_no_en", en_seen, 0);
        end

        // Random phase
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 35),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 99) < 90),
                  ($urandom_range(0, 99) < 6));
        end

        // Async reset in the middle of RUN
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        key(9);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        chk("pre_reset_running", 32'(bus.running), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async");
        @(posedge clk);
        #1 chk("reset_held_state", 32'(bus.state), S_IDLE);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        idle_cyc();
        idle_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control front-end of the kitchen-timer datapath: collects BCD keypad digits into an entry buffer, loads them into the down-counter chain (minutes, tens-of-seconds mod-6, units-of-seconds), and drives the chain's `en`/`load`/`clearn` inputs from a 1 Hz prescaler. It sits directly upstream of the digit counters and consumes their all-zero indication to detect expiry.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per count tick (≥2).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces every register to its reset value.
- `clear` in 1: synchronous user clear pulse.
- `start` in 1: start/resume pulse.
- `stop` in 1: pause pulse.
- `key_valid` in 1: one-cycle strobe for `key_digit`.
- `key_digit` in 4: BCD keypad value.
- `door_closed` in 1: interlock; present only with `TIMER_CTRL_DOOR_EN`.
- `zero` in 1: AND of all counter `count_end` outputs.
- `min_in`, `sec_tens_in`, `sec_ones_in` out 4 each: load values for the counters (registered buffer).
- `load` out 1: one-cycle load strobe to all counters.
- `en` out 1: count-tick strobe to the units counter.
- `clearn` out 1: active-low clear to counters.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `state` out 3: IDLE=0, SET=1, LOAD=2, RUN=3, PAUSE=4, DONE=5.

## Operation
- States: IDLE, SET, LOAD, RUN, PAUSE, DONE. `clear` has highest priority in every state: next state IDLE, buffer ← 000.
- Entry buffer: 3 BCD digits {min, tens, ones}. Accepted digit (≤9, in IDLE/SET/DONE): ones←digit, tens←ones, min←tens, old min discarded. Digits 10–15 ignored, no state change.
- IDLE: accepted digit → SET. `start` ignored.
- SET: `start` (door closed, buffer ≠ 000) → LOAD; `start` with buffer 000 ignored. If `start` and `key_valid` coincide, start wins, digit dropped.
- Tens clamp: on LOAD entry, buffer tens > 5 is rewritten to 5 (e.g. 1:79 loads as 1:59).
- LOAD: `load`=1 for exactly this cycle, `en`=0; prescaler ← 0; next state RUN unconditionally (except `clear`).
- RUN: prescaler increments, wraps to 0 after TICK_DIV−1. `en` = (state==RUN) & (prescaler==TICK_DIV−1) & !`zero` (combinational on `zero`). `zero`=1 → DONE, no tick issued. `stop` or door open → PAUSE; if both `stop` and `zero`, DONE wins. `start` ignored.
- PAUSE: prescaler holds its value; `start` (door closed) → RUN, resuming from held value.
- DONE: `done`=1; accepted digit → SET with buffer 00d (old buffer discarded); `start` ignored.
- `clearn` = 0 in IDLE, 1 otherwise; counters therefore clear every cycle while idle.
- `running` = (state==RUN); `done` = (state==DONE).
- Buffer not modified in LOAD/RUN/PAUSE (digits ignored).

## Timing
- Reset values: state IDLE, buffer 000, prescaler 0, `load` 0, `en` 0, `clearn` 0, `running` 0, `done` 0.
- `reset` mid-RUN: all outputs return to reset values immediately (asynchronously); no tick or load issued.
- `start` sampled at edge N in SET → `load` high in cycle N+1 → RUN from N+2; first `en` at N+2+TICK_DIV−1.
- `en` period in uninterrupted RUN: exactly TICK_DIV cycles, width 1 cycle.
- `zero` sampled each RUN cycle; DONE entered on the edge after `zero` observed high; `en` never pulses with `zero`=1 (counter wrap to 5/9 prevented).
- Digit accepted at edge of `key_valid`; `*_in` outputs reflect it next cycle.

## Configuration
- `TIMER_CTRL_DOOR_EN` defined: `door_closed` port exists; `start` accepted only when `door_closed`=1; door opening in RUN → PAUSE on next edge.
- Not defined: port absent, door treated as always closed.

## Test plan
- TICK_DIV=4; reset, keys 1,3,0 → `min_in/sec_tens_in/sec_ones_in`=1/3/0, state SET, `clearn`=1 after first key.
- Keys 2,7,5,9 → buffer 7/5/9 (2 discarded); key 12 → no change; `start` → `load` one cycle, tens loaded as 5.
- RUN with `zero`=0 → `en` pulses every 4 cycles; `stop` after 2 cycles, `start` 10 cycles later → next `en` exactly 2 cycles after resume.
- `zero` raised coincident with prescaler=3 → no `en`, DONE next edge, `done`=1; key 4 → SET, buffer 0/0/4.
- `clear` same cycle as `start` in SET → IDLE, buffer 000, `clearn`=0, no `load`; async `reset` mid-RUN → all outputs reset immediately.
- With `TIMER_CTRL_DOOR_EN`: `start` with door open ignored; door opens in RUN → PAUSE, `en` stops.
